posit_shift_arbiter: RTL and testbench
======================================

# posit_shift_arbiter

Shares one dynamic left barrel shifter (N-bit data, Bs-bit shift amount) between two requesters in the posit datapath, e.g. regime/exponent extraction and fraction normalisation. Each requester presents an operand and a shift amount over a valid/ready handshake. Round-robin arbitration picks one per cycle. The shift runs through a two-stage elastic pipeline, and results return with source ID, tag and a sticky bit over an output valid/ready handshake.

## Interface
- N, default 8, data width.
- Bs, default log2(N) (ceiling), shift-amount width.
- TW, default 2, requester tag width.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_data  in  N  operand.
- req0_shamt  in  Bs  left-shift amount.
- req0_tag  in  TW  opaque tag, returned with the result.
- req1_valid / req1_ready / req1_data / req1_shamt / req1_tag: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  N  shifted operand.
- res_sticky  out  1  OR of all bits shifted out.
- res_src  out  1  requester ID (0/1).
- res_tag  out  TW  tag of the originating request.

## Operation
- Handshake rules:
  - Transfer occurs when valid && ready are high at a rising edge.
  - Requesters hold valid, data, shamt and tag stable until transfer.
  - reqX_ready may depend on reqX_valid; no valid may depend on ready.
- Stage S1 (operand register: valid1, data, shamt, src, tag) and stage S2 (result register: res_*).
- Stall and advance:
  - s2_free = !res_valid || res_ready.
  - s1_adv = valid1 && s2_free.
  - can_accept = !valid1 || s1_adv.
- Arbitration:
  - last_grant register, reset value 1, so requester 0 wins first.
  - When both requesters are valid and can_accept is high, grant !last_grant. When only one is valid, grant it.
  - last_grant updates only on an actual transfer.
  - reqX_ready = can_accept && grantX. Ready is never high to both requesters in the same cycle.
- Shift, computed combinationally from S1:
  - data << shamt, zero fill, truncated to N bits.
  - sticky = OR of data[N-1 : N-shamt] for 0 < shamt < N; 0 when shamt = 0.
  - shamt >= N (non-power-of-two N): result 0, sticky = OR of all data bits.
- Ordering: results leave in acceptance order. No reordering, drop or duplication.
- Throughput: one request per cycle sustained while res_ready is high.

## Timing
- Reset (asynchronous, immediate): valid1=0, res_valid=0, res_data=0, res_sticky=0, res_src=0, res_tag=0, last_grant=1, both reqX_ready=0.
- Latency: handshake at edge E → S1 loads at E → S2 loads at E+1 → res_valid high in the cycle after E+1 (two cycles).
- Backpressure:
  - res_valid high with res_ready low: S2 holds and S1 holds if full.
  - reqX_ready drops the same cycle (combinational from the stall).
  - Throughput recovers on the first cycle res_ready is high, with no bubble.
- Simultaneous accept and drain of the same stage in one cycle is legal and required.
- Reset asserted mid-operation discards in-flight entries. After release, the first grant goes to requester 0.

## Structure
- Shared package posit_pkg: Bs log2 function (ceiling), requester-ID type, default TW constant.
- Sub-module: one instance of the codebase's existing dynamic left barrel shifter (N, Bs) on the S1 outputs.
- Sticky logic, arbiter and pipeline registers live in this module. The arbiter is not a separate module.

## Test plan
- Reset: assert rst_n=0 with random inputs → all outputs 0 immediately. After release with only req1_valid=1 → req1 granted.
- Single request: req0 data=8'b0000_0101, shamt=3, tag=2, res_ready=1 → two cycles later res_data=8'b0010_1000, sticky=0, src=0, tag=2, res_valid for exactly one cycle.
- Fairness: both requesters valid continuously, res_ready=1 → grants 0,1,0,1…, one result per cycle, src alternating starting at 0.
- Backpressure: stream 6 requests, hold res_ready=0 for 3 cycles → at most 2 in flight, reqX_ready low while full, all 6 results delivered in order, none lost.
- Sticky/boundaries:
  - data=8'b1100_0001, shamt=2 → res_data=8'b0000_0100, sticky=1.
  - data=8'b0000_0001, shamt=7 → res_data=8'b1000_0000, sticky=0.
  - shamt=0 → data unchanged, sticky=0.
- Mid-operation reset: S1 and S2 full, pulse rst_n low → res_valid drops asynchronously, no stale result after release, next grant goes to req0.

Source files
------------

// File: rtl/posit_pkg.sv
// posit_pkg: shared constants, requester-ID type and width helper for the posit datapath.
package posit_pkg;

   localparam int TW_DEF = 2;

   typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_e;

   // Ceiling log2, floored at 1 so a shift-amount port never collapses to zero width.
   function automatic int clog2_ceil(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/posit_shift_arbiter_lshift.sv
// posit_shift_arbiter_lshift: dynamic left barrel shifter, zero fill, result 0 once shamt >= N.
module posit_shift_arbiter_lshift #(
   parameter int N  = 8,
   parameter int Bs = 3
) (
   input  logic [N-1:0]  data_i,
   input  logic [Bs-1:0] shamt_i,
   output logic [N-1:0]  data_o
);

   always_comb begin
      data_o = data_i;
      for (int k = 0; k < Bs; k++)
         if (shamt_i[k]) data_o = ((1 << k) >= N) ? '0 : data_o << (1 << k);
   end

endmodule

// File: rtl/posit_shift_arbiter.sv
// posit_shift_arbiter: round-robin share of one left barrel shifter between two requesters,
// with an operand stage (S1) and a result stage (S2) forming a two-deep elastic pipeline.
module posit_shift_arbiter
   import posit_pkg::*;
#(
   parameter int N  = 8,
   parameter int Bs = clog2_ceil(N),
   parameter int TW = TW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [N-1:0]  req0_data,
   input  logic [Bs-1:0] req0_shamt,
   input  logic [TW-1:0] req0_tag,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [N-1:0]  req1_data,
   input  logic [Bs-1:0] req1_shamt,
   input  logic [TW-1:0] req1_tag,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [N-1:0]  res_data,
   output logic          res_sticky,
   output logic          res_src,
   output logic [TW-1:0] res_tag
);

   logic          valid1_q, valid1_d;
   logic [N-1:0]  data1_q, data1_d;
   logic [Bs-1:0] shamt1_q, shamt1_d;
   src_e          src1_q, src1_d;
   logic [TW-1:0] tag1_q, tag1_d;
   logic          res_valid_q, res_valid_d;
   logic [N-1:0]  res_data_q, res_data_d;
   logic          res_sticky_q, res_sticky_d;
   src_e          res_src_q, res_src_d;
   logic [TW-1:0] res_tag_q, res_tag_d;
   logic          last_grant_q, last_grant_d;
   logic          s2_free, s1_adv, can_accept, grant0, grant1, accept;
   logic [N-1:0]  shifted, out_mask;
   logic          sticky;

   assign s2_free    = !res_valid_q || res_ready;
   assign s1_adv     = valid1_q && s2_free;
   assign can_accept = !valid1_q || s1_adv;

   // On contention, the requester not granted last time wins.
   assign grant0     = req0_valid && (!req1_valid || last_grant_q);
   assign grant1     = req1_valid && (!req0_valid || !last_grant_q);
   assign req0_ready = rst_n && can_accept && grant0;
   assign req1_ready = rst_n && can_accept && grant1;
   assign accept     = req0_ready || req1_ready;

   posit_shift_arbiter_lshift #(.N(N), .Bs(Bs)) u_lshift (
      .data_i  (data1_q),
      .shamt_i (shamt1_q),
      .data_o  (shifted)
   );

   // Mask covers the top shamt bits; it saturates to all ones when shamt >= N.
   assign out_mask = ~({N{1'b1}} >> shamt1_q);
   assign sticky   = |(data1_q & out_mask);

   always_comb begin
      valid1_d     = accept || (valid1_q && !s1_adv);
      data1_d      = accept ? (req1_ready ? req1_data : req0_data) : data1_q;
      shamt1_d     = accept ? (req1_ready ? req1_shamt : req0_shamt) : shamt1_q;
      src1_d       = accept ? (req1_ready ? SRC1 : SRC0) : src1_q;
      tag1_d       = accept ? (req1_ready ? req1_tag : req0_tag) : tag1_q;
      res_valid_d  = s1_adv || (res_valid_q && !res_ready);
      res_data_d   = s1_adv ? shifted : res_data_q;
      res_sticky_d = s1_adv ? sticky : res_sticky_q;
      res_src_d    = s1_adv ? src1_q : res_src_q;
      res_tag_d    = s1_adv ? tag1_q : res_tag_q;
      last_grant_d = accept ? req1_ready : last_grant_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid1_q     <= 1'b0;
         data1_q      <= '0;
         shamt1_q     <= '0;
         src1_q       <= SRC0;
         tag1_q       <= '0;
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_sticky_q <= 1'b0;
         res_src_q    <= SRC0;
         res_tag_q    <= '0;
         last_grant_q <= 1'b1;
      end else begin
         valid1_q     <= valid1_d;
         data1_q      <= data1_d;
         shamt1_q     <= shamt1_d;
         src1_q       <= src1_d;
         tag1_q       <= tag1_d;
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_sticky_q <= res_sticky_d;
         res_src_q    <= res_src_d;
         res_tag_q    <= res_tag_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_sticky = res_sticky_q;
   assign res_src    = res_src_q;
   assign res_tag    = res_tag_q;

endmodule

// File: tb/tb_posit_shift_arbiter.sv
// tb_posit_shift_arbiter: directed vectors and hand-written sequences for the shared shifter
// with a scoreboard in acceptance order.
module tb_posit_shift_arbiter;

   localparam int N  = 8;
   localparam int BS = 3;
   localparam int TW = 2;

   typedef struct packed {
      logic [N-1:0]  d;
      logic          st;
      logic          src;
      logic [TW-1:0] tag;
   } exp_t;

   typedef struct {
      logic          src;
      logic [N-1:0]  d;
      logic [BS-1:0] s;
      logic [TW-1:0] tag;
      logic [N-1:0]  ed;
      logic          es;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [N-1:0]  req0_data, req1_data, res_data;
   logic [BS-1:0] req0_shamt, req1_shamt;
   logic [TW-1:0] req0_tag, req1_tag, res_tag;
   logic          res_valid, res_ready, res_sticky, res_src;

   int   checks = 0;
   int   errors = 0;
   int   n_rcv;
   int   occ;
   logic x0, x1;
   exp_t q[$];
   vec_t tbl[8];

   always #5 clk = ~clk;

   posit_shift_arbiter #(.N(N), .Bs(BS), .TW(TW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req0_shamt (req0_shamt),
      .req0_tag   (req0_tag),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .req1_shamt (req1_shamt),
      .req1_tag   (req1_tag),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_sticky (res_sticky),
      .res_src    (res_src),
      .res_tag    (res_tag)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bit-serial reference: shift one place at a time, collecting what falls off the top.
   function automatic exp_t predict(input logic [N-1:0] d, input logic [BS-1:0] s,
                                    input logic src, input logic [TW-1:0] tag);
      exp_t e;
      e.d   = d;
      e.st  = 1'b0;
      e.src = src;
      e.tag = tag;
      for (int i = 0; i < int'(s); i++) begin
         e.st = e.st | e.d[N-1];
         e.d  = {e.d[N-2:0], 1'b0};
      end
      return e;
   endfunction

   task automatic set_req(input logic src, input logic v, input logic [N-1:0] d,
                          input logic [BS-1:0] s, input logic [TW-1:0] t);
      if (src) begin
         req1_valid = v; req1_data = d; req1_shamt = s; req1_tag = t;
      end else begin
         req0_valid = v; req0_data = d; req0_shamt = s; req0_tag = t;
      end
   endtask

   task automatic sample();
      exp_t e;
      #1;
      x0  = req0_valid && req0_ready;
      x1  = req1_valid && req1_ready;
      occ = q.size();
      chk("both_ready", {31'b0, req0_ready && req1_ready}, 0);
      if (res_valid && res_ready) begin
         if (q.size() == 0) chk("spurious_res", {31'b0, res_valid}, 0);
         else begin
            e = q.pop_front();
            n_rcv++;
            chk("sb_data", res_data, e.d);
            chk("sb_sticky", res_sticky, e.st);
            chk("sb_src", res_src, e.src);
            chk("sb_tag", res_tag, e.tag);
         end
      end
      if (x0) q.push_back(predict(req0_data, req0_shamt, 1'b0, req0_tag));
      if (x1) q.push_back(predict(req1_data, req1_shamt, 1'b1, req1_tag));
   endtask

   task automatic adv();
      @(negedge clk);
   endtask

   task automatic drain();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b1;
      repeat (4) begin
         sample();
         adv();
      end
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic do_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b0;
      q.delete();
      #2;
      rst_n = 1'b1;
      adv();
   endtask

   initial begin
      tbl[0] = '{1'b0, 8'h05, 3'd3, 2'd2, 8'h28, 1'b0};
      tbl[1] = '{1'b0, 8'hC1, 3'd2, 2'd1, 8'h04, 1'b1};
      tbl[2] = '{1'b1, 8'h01, 3'd7, 2'd0, 8'h80, 1'b0};
      tbl[3] = '{1'b1, 8'hAA, 3'd0, 2'd3, 8'hAA, 1'b0};
      tbl[4] = '{1'b0, 8'hFF, 3'd1, 2'd0, 8'hFE, 1'b1};
      tbl[5] = '{1'b1, 8'h55, 3'd4, 2'd1, 8'h50, 1'b1};
      tbl[6] = '{1'b0, 8'h80, 3'd7, 2'd2, 8'h00, 1'b1};
      tbl[7] = '{1'b1, 8'h0F, 3'd4, 2'd3, 8'hF0, 1'b0};
      n_rcv = 0;

      // Reset with arbitrary inputs: everything reads zero straight away.
      req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'($urandom);
      req0_data = 8'($urandom); req0_shamt = 3'($urandom); req0_tag = 2'($urandom);
      req1_data = 8'($urandom); req1_shamt = 3'($urandom); req1_tag = 2'($urandom);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_sticky", res_sticky, 0);
      chk("rst_res_src", res_src, 0);
      chk("rst_res_tag", res_tag, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      req0_valid = 1'b0;
      set_req(1'b1, 1'b1, 8'h03, 3'd1, 2'd3);
      res_ready = 1'b1;
      adv();
      rst_n = 1'b1;
      sample();
      chk("post_rst_req1_ready", req1_ready, 1);
      chk("post_rst_req0_ready", req0_ready, 0);
      adv();
      drain();

      // Single requests from the table: exact two-cycle latency, one-cycle result pulse.
      for (int i = 0; i < 8; i++) begin
         set_req(tbl[i].src, 1'b1, tbl[i].d, tbl[i].s, tbl[i].tag);
         res_ready = 1'b1;
         sample();
         chk("vec_ready", tbl[i].src ? x1 : x0, 1);
         adv();
         set_req(tbl[i].src, 1'b0, tbl[i].d, tbl[i].s, tbl[i].tag);
         sample();
         chk("vec_lat1_valid", res_valid, 0);
         adv();
         sample();
         chk("vec_valid", res_valid, 1);
         chk("vec_data", res_data, tbl[i].ed);
         chk("vec_sticky", res_sticky, tbl[i].es);
         chk("vec_src", res_src, tbl[i].src);
         chk("vec_tag", res_tag, tbl[i].tag);
         adv();
         sample();
         chk("vec_pulse_end", res_valid, 0);
         adv();
      end
      chk("vec_empty", q.size(), 0);

      // Fairness: both requesters always valid, grants alternate starting with 0.
      do_reset();
      n_rcv = 0;
      set_req(1'b0, 1'b1, 8'h12, 3'd1, 2'd0);
      set_req(1'b1, 1'b1, 8'h34, 3'd2, 2'd1);
      res_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         sample();
         chk("fair_g0", x0, (c % 2) == 0);
         chk("fair_g1", x1, (c % 2) == 1);
         adv();
         if (x0) set_req(1'b0, 1'b1, 8'($urandom), 3'($urandom), 2'($urandom));
         if (x1) set_req(1'b1, 1'b1, 8'($urandom), 3'($urandom), 2'($urandom));
      end
      chk("fair_throughput", n_rcv, 6);
      drain();

      // Backpressure: six requests, consumer stalls for three cycles.
      begin
         int sent;
         sent = 0;
         n_rcv = 0;
         for (int c = 0; c < 40 && (sent < 6 || q.size() > 0); c++) begin
            set_req(1'b0, sent < 6, 8'(8'h21 * (sent + 1)), 3'(sent), 2'(sent));
            res_ready = !(c >= 2 && c < 5);
            sample();
            chk("bp_inflight", {31'b0, occ > 2}, 0);
            if (occ == 2 && !res_ready) chk("bp_ready_low", req0_ready, 0);
            if (x0) sent++;
            adv();
         end
         chk("bp_delivered", n_rcv, 6);
         chk("bp_empty", q.size(), 0);
      end

      // Mid-operation reset with both stages full and last grant on requester 0.
      res_ready = 1'b0;
      set_req(1'b0, 1'b1, 8'h81, 3'd1, 2'd1);
      sample();
      adv();
      set_req(1'b0, 1'b1, 8'h3C, 3'd2, 2'd2);
      sample();
      adv();
      req0_valid = 1'b0;
      sample();
      chk("mid_full_valid", res_valid, 1);
      chk("mid_full_occ", occ, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_data", res_data, 0);
      #1 rst_n = 1'b1;
      q.delete();
      adv();
      res_ready = 1'b1;
      repeat (2) begin
         sample();
         chk("mid_no_stale", res_valid, 0);
         adv();
      end
      set_req(1'b0, 1'b1, 8'h07, 3'd5, 2'd0);
      set_req(1'b1, 1'b1, 8'h70, 3'd1, 2'd3);
      sample();
      chk("mid_grant0", x0, 1);
      chk("mid_grant1", x1, 0);
      adv();
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
